ads3241_spi_cfg: RTL and testbench
==================================

Name: ads3241_spi_cfg

Overview:
- Configuration sequencer for the ADS3241 dual-channel ADC.
- After system reset it pulses the ADC hardware reset and waits a settle time.
- It then writes a table of register words over the ADC's 3-wire SPI port (SEN/SCLK/SDATA) and raises cfg_done.
- Once done, it grants single host register writes through a req/ack handshake. It sits beside the LVDS capture deserializer in the same clock domain as sclk.

Parameters:
CLK_DIV, 4, sclk cycles per adc_sclk half-period (>=1)
RST_PULSE, 16, sclk cycles adc_reset held high
RST_WAIT, 1000, sclk cycles after adc_reset falls before first frame
NUM_REGS, 4, init table entries (>=1)

Ports:
sclk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_table  in  16*NUM_REGS  init words, entry i = bits [16i+15:16i], {addr[7:0],data[7:0]}
start  in  1  re-run full init sequence (pulse)
wr_req  in  1  host write request, held until wr_ack
wr_addr  in  8  host register address
wr_data  in  8  host register data
wr_ack  out  1  one-cycle acceptance pulse
busy  out  1  sequence or frame in progress
cfg_done  out  1  init table fully written (sticky)
adc_reset  out  1  ADC hardware reset, active-high
adc_sen  out  1  SPI enable, active-low
adc_sclk  out  1  SPI clock, idles low
adc_sdata  out  1  SPI data, MSB first

Behaviour:
- Reset state, held while rst=1:
  - adc_reset=0, adc_sen=1, adc_sclk=0, adc_sdata=0
  - busy=1, cfg_done=0, wr_ack=0
  - FSM returns to S_HWRST.
- rst mid-frame: the frame is aborted. SEN is high on the first edge with rst=1, and no partial completion is signalled.
- FSM states: S_HWRST, S_WAIT, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_IDLE.
  - S_HWRST: adc_reset=1 for exactly RST_PULSE cycles, starting on the first cycle after rst falls.
  - S_WAIT: adc_reset=0 for RST_WAIT cycles.
  - S_LOAD: 1 cycle. Shift register gets cfg_table entry idx (init) or {wr_addr,wr_data} (host, captured at ack). adc_sen does not change.
  - S_SHIFT: adc_sen=0 for 16 bits.
    - Each bit: CLK_DIV cycles adc_sclk=0, then CLK_DIV cycles adc_sclk=1.
    - adc_sdata is updated only at the start of a low phase, so it is stable across the entire high phase (ADC samples on rising edge).
    - Bit 15 is driven on the cycle SEN falls.
  - S_HOLD: CLK_DIV cycles, adc_sclk=0, SEN still low.
  - S_GAP: adc_sen=1, adc_sdata=0 for 2*CLK_DIV cycles.
  - After S_GAP, an init sequence with idx<NUM_REGS-1 increments idx and returns to S_LOAD. Otherwise go to S_IDLE.
  - On entering S_IDLE after init, cfg_done=1 and busy=0 on the same edge.
- Frame timing: SEN-low duration is exactly 33*CLK_DIV cycles. Frame-to-frame spacing is 1 + 33*CLK_DIV + 2*CLK_DIV cycles.
- Host write handshake:
  - Accepted only in S_IDLE with cfg_done=1 and start=0.
  - wr_ack=1 for exactly the acceptance cycle. addr/data are captured on that edge, busy=1 from the next cycle.
  - The frame runs S_LOAD..S_GAP, then returns to S_IDLE, busy=0, cfg_done unchanged.
  - wr_req while busy or before cfg_done: ignored, no ack. The request stays pending.
- start:
  - Honoured only in S_IDLE. It clears cfg_done, sets busy and goes to S_HWRST on the next edge.
  - Ignored while busy.
  - start with wr_req in the same cycle: start wins, no wr_ack.
- cfg_table must be stable while busy. It is sampled at each S_LOAD.
- Counters:
  - div counter: clog2(CLK_DIV+1) bits
  - bit counter: 4 bits, wraps 15->0 ends S_SHIFT
  - idx: clog2(NUM_REGS) bits (min 1)
  - delay counter: wide enough for max(RST_PULSE, RST_WAIT)
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
1. Power-up. CLK_DIV=2, RST_PULSE=4, RST_WAIT=10, NUM_REGS=2, table entry0=0x0001, entry1=0x4210. Required:
   - adc_reset high cycles 0-3 after rst release.
   - Bus model captures 0x0001 then 0x4210.
   - SEN-low width 66 cycles, gap 4 cycles.
   - cfg_done and busy=0 assert at cycle 155.
2. Host write after cfg_done, wr_addr=0x3D, wr_data=0xA5. Required:
   - wr_ack high exactly 1 cycle.
   - Model captures 0x3DA5.
   - busy high 71 cycles (CLK_DIV=2), cfg_done stays 1.
3. wr_req asserted at cycle 20 (mid-init) and held. Required:
   - No wr_ack until the cycle after cfg_done rises.
   - Exactly one ack and one frame.
4. start and wr_req in the same S_IDLE cycle. Required:
   - No wr_ack, cfg_done=0 and adc_reset=1 next cycle.
   - Full table replayed.
   - The held wr_req is acked after the new cfg_done.
5. rst asserted during bit 7 of frame 0. Required:
   - Next edge adc_sen=1, adc_sclk=0, busy=1, cfg_done=0.
   - After release the full sequence restarts with entry 0.
6. Protocol checker, CLK_DIV=4, random table. Required:
   - adc_sclk period 8 cycles.
   - adc_sdata never changes while adc_sclk=1 or in the cycle adc_sclk rises.
   - Exactly 16 rising edges per SEN-low window.

Source files
------------

// File: rtl/ads3241_spi_cfg.sv
// ADS3241 configuration sequencer: pulses the ADC hardware reset, writes the
// init register table over 3-wire SPI, then serves single host register writes.
module ads3241_spi_cfg #(
   parameter int CLK_DIV   = 4,
   parameter int RST_PULSE = 16,
   parameter int RST_WAIT  = 1000,
   parameter int NUM_REGS  = 4
) (
   input  logic                     sclk,
   input  logic                     rst,
   input  logic [16*NUM_REGS-1:0]   cfg_table,
   input  logic                     start,
   input  logic                     wr_req,
   input  logic [7:0]               wr_addr,
   input  logic [7:0]               wr_data,
   output logic                     wr_ack,
   output logic                     busy,
   output logic                     cfg_done,
   output logic                     adc_reset,
   output logic                     adc_sen,
   output logic                     adc_sclk,
   output logic                     adc_sdata
);

   localparam int DIV_W   = $clog2(CLK_DIV + 1);
   localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int DLY_A   = (RST_PULSE > RST_WAIT) ? RST_PULSE : RST_WAIT;
   localparam int DLY_MAX = (DLY_A > 2 * CLK_DIV) ? DLY_A : 2 * CLK_DIV;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [2:0] {
      S_HWRST, S_WAIT, S_LOAD, S_SHIFT, S_HOLD, S_GAP, S_IDLE
   } state_t;

   state_t             state_q, state_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [3:0]         bit_q, bit_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [15:0]        sr_q, sr_d;
   logic [15:0]        host_q, host_d;
   logic               init_q, init_d;
   logic               wr_ack_q, wr_ack_d;
   logic               busy_q, busy_d;
   logic               cfg_done_q, cfg_done_d;
   logic               adc_reset_q, adc_reset_d;
   logic               sen_q, sen_d;
   logic               sclk_q, sclk_d;
   logic               sdata_q, sdata_d;
   logic [15:0]        word;

   always_comb begin
      // NOTE: every variable gets its hold value first so no path through the case infers a latch.
      state_d     = state_q;
      dly_d       = dly_q;
      div_d       = div_q;
      bit_d       = bit_q;
      idx_d       = idx_q;
      sr_d        = sr_q;
      host_d      = host_q;
      init_d      = init_q;
      wr_ack_d    = 1'b0;
      busy_d      = busy_q;
      cfg_done_d  = cfg_done_q;
      adc_reset_d = adc_reset_q;
      sen_d       = sen_q;
      sclk_d      = sclk_q;
      sdata_d     = sdata_q;
      word        = init_q ? cfg_table[{idx_q, 4'b0000} +: 16] : host_q;

      case (state_q)
         S_HWRST: begin
            busy_d      = 1'b1;
            adc_reset_d = 1'b1;
            if (dly_q == DLY_W'(RST_PULSE)) begin
               state_d     = S_WAIT;
               dly_d       = DLY_W'(1);
               adc_reset_d = 1'b0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (dly_q == DLY_W'(RST_WAIT)) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_LOAD: begin
            // Bit 15 leaves on the same edge SEN falls; the rest waits in sr.
            state_d = S_SHIFT;
            sdata_d = word[15];
            sr_d    = {word[14:0], 1'b0};
            sen_d   = 1'b0;
            sclk_d  = 1'b0;
            div_d   = DIV_W'(1);
            bit_d   = 4'd0;
         end
         S_SHIFT: begin
            if (div_q == DIV_W'(CLK_DIV)) begin
               div_d = DIV_W'(1);
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  bit_d  = bit_q + 4'd1;
                  if (bit_q == 4'd15) begin
                     state_d = S_HOLD;
                  end else begin
                     sdata_d = sr_q[15];
                     sr_d    = {sr_q[14:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (div_q == DIV_W'(CLK_DIV)) begin
               state_d = S_GAP;
               sen_d   = 1'b1;
               sdata_d = 1'b0;
               dly_d   = DLY_W'(1);
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_GAP: begin
            if (dly_q == DLY_W'(2 * CLK_DIV)) begin
               if (init_q && (idx_q != IDX_W'(NUM_REGS - 1))) begin
                  state_d = S_LOAD;
                  idx_d   = idx_q + 1'b1;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  if (init_q) cfg_done_d = 1'b1;
               end
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_IDLE: begin
            // start outranks a simultaneous host request.
            if (start) begin
               state_d     = S_HWRST;
               dly_d       = DLY_W'(1);
               adc_reset_d = 1'b1;
               cfg_done_d  = 1'b0;
               busy_d      = 1'b1;
               init_d      = 1'b1;
            end else if (wr_req && cfg_done_q) begin
               state_d  = S_LOAD;
               host_d   = {wr_addr, wr_data};
               wr_ack_d = 1'b1;
               busy_d   = 1'b1;
               init_d   = 1'b0;
            end
         end
         default: state_d = S_HWRST;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q     <= S_HWRST;
         dly_q       <= '0;
         div_q       <= '0;
         bit_q       <= 4'd0;
         idx_q       <= '0;
         sr_q        <= 16'h0000;
         host_q      <= 16'h0000;
         init_q      <= 1'b1;
         wr_ack_q    <= 1'b0;
         busy_q      <= 1'b1;
         cfg_done_q  <= 1'b0;
         adc_reset_q <= 1'b0;
         sen_q       <= 1'b1;
         sclk_q      <= 1'b0;
         sdata_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         dly_q       <= dly_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         idx_q       <= idx_d;
         sr_q        <= sr_d;
         host_q      <= host_d;
         init_q      <= init_d;
         wr_ack_q    <= wr_ack_d;
         busy_q      <= busy_d;
         cfg_done_q  <= cfg_done_d;
         adc_reset_q <= adc_reset_d;
         sen_q       <= sen_d;
         sclk_q      <= sclk_d;
         sdata_q     <= sdata_d;
      end
   end

   assign wr_ack    = wr_ack_q;
   assign busy      = busy_q;
   assign cfg_done  = cfg_done_q;
   assign adc_reset = adc_reset_q;
   assign adc_sen   = sen_q;
   assign adc_sclk  = sclk_q;
   assign adc_sdata = sdata_q;

endmodule

// File: tb/tb_ads3241_spi_cfg.sv
// Directed bench for ads3241_spi_cfg: a CLK_DIV=2 instance for sequencing and
// handshake tests, a CLK_DIV=4 instance with a random table for SPI protocol checks.
module tb_ads3241_spi_cfg;

   logic sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Instance 1: CLK_DIV=2, RST_PULSE=4, RST_WAIT=10, NUM_REGS=2
   logic        rst, start, wr_req;
   logic [7:0]  wr_addr, wr_data;
   logic [31:0] table1;
   logic        wr_ack1, busy1, cfg_done1, adc_reset1, adc_sen1, adc_sclk1, adc_sdata1;

   // Instance 2: CLK_DIV=4, random table, protocol checks only
   logic        rst2, zero1;
   logic [7:0]  zero8;
   logic [31:0] table2;
   logic        wr_ack2, busy2, cfg_done2, adc_reset2, adc_sen2, adc_sclk2, adc_sdata2;

   ads3241_spi_cfg #(.CLK_DIV(2), .RST_PULSE(4), .RST_WAIT(10), .NUM_REGS(2)) dut1 (
      .sclk(sclk), .rst(rst), .cfg_table(table1), .start(start), .wr_req(wr_req),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack1), .busy(busy1),
      .cfg_done(cfg_done1), .adc_reset(adc_reset1), .adc_sen(adc_sen1),
      .adc_sclk(adc_sclk1), .adc_sdata(adc_sdata1)
   );

   ads3241_spi_cfg #(.CLK_DIV(4), .RST_PULSE(4), .RST_WAIT(10), .NUM_REGS(2)) dut2 (
      .sclk(sclk), .rst(rst2), .cfg_table(table2), .start(zero1), .wr_req(zero1),
      .wr_addr(zero8), .wr_data(zero8), .wr_ack(wr_ack2), .busy(busy2),
      .cfg_done(cfg_done2), .adc_reset(adc_reset2), .adc_sen(adc_sen2),
      .adc_sclk(adc_sclk2), .adc_sdata(adc_sdata2)
   );

   int checks = 0;
   int errors = 0;

   task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus models, updated once per clock, sampled 1 time unit after the edge.
   int          cyc;
   logic        p_sen1, p_sclk1;
   logic [15:0] sh1;
   logic [15:0] frames1[$];
   int          falls1[$], rises1[$];

   logic        p_sen2, p_sclk2, p_sdata2;
   logic [15:0] sh2;
   logic [15:0] frames2[$];
   int          rises_per2[$];
   int          rcnt2, last_rise2, first_per2, per_bad2, sdat_bad2;

   function automatic logic [15:0] fr1(input int i);
      return (i < frames1.size()) ? frames1[i] : 16'hxxxx;
   endfunction
   function automatic logic [15:0] fr2(input int i);
      return (i < frames2.size()) ? frames2[i] : 16'hxxxx;
   endfunction
   function automatic int fall1(input int i);
      return (i < falls1.size()) ? falls1[i] : -1000;
   endfunction
   function automatic int rise1(input int i);
      return (i < rises1.size()) ? rises1[i] : -1000;
   endfunction
   function automatic int rp2(input int i);
      return (i < rises_per2.size()) ? rises_per2[i] : -1;
   endfunction

   task clear1();
      frames1.delete();
      falls1.delete();
      rises1.delete();
   endtask

   task step();
      logic rising2;
      @(posedge sclk);
      #1;
      cyc++;
      if (!adc_sen1 && adc_sclk1 && !p_sclk1) sh1 = {sh1[14:0], adc_sdata1};
      if (p_sen1 && !adc_sen1) falls1.push_back(cyc);
      if (!p_sen1 && adc_sen1) begin
         rises1.push_back(cyc);
         frames1.push_back(sh1);
      end
      p_sen1  = adc_sen1;
      p_sclk1 = adc_sclk1;

      rising2 = adc_sclk2 && !p_sclk2;
      if (p_sen2 && !adc_sen2) begin
         rcnt2      = 0;
         last_rise2 = -1;
      end
      if (!adc_sen2 && rising2) begin
         sh2 = {sh2[14:0], adc_sdata2};
         rcnt2++;
         if (last_rise2 >= 0) begin
            if (first_per2 < 0) first_per2 = cyc - last_rise2;
            if (cyc - last_rise2 != 8) per_bad2++;
         end
         last_rise2 = cyc;
      end
      if (adc_sclk2 && (adc_sdata2 !== p_sdata2)) sdat_bad2++;
      if (!p_sen2 && adc_sen2) begin
         rises_per2.push_back(rcnt2);
         frames2.push_back(sh2);
      end
      p_sen2   = adc_sen2;
      p_sclk2  = adc_sclk2;
      p_sdata2 = adc_sdata2;
   endtask

   int rhi, rfirst, rlast, done_cyc, acks, ack_cyc, bcnt, dlow;
   bit seen;

   initial begin
      rst = 1'b1; start = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
      table1 = {16'h4210, 16'h0001};
      rst2 = 1'b1; zero1 = 1'b0; zero8 = 8'h00; table2 = 32'h0;
      cyc = 0; p_sen1 = 1'b1; p_sclk1 = 1'b0; sh1 = 16'h0;
      p_sen2 = 1'b1; p_sclk2 = 1'b0; p_sdata2 = 1'b0; sh2 = 16'h0;
      rcnt2 = 0; last_rise2 = -1; first_per2 = -1; per_bad2 = 0; sdat_bad2 = 0;

      // Reset state: {adc_reset,sen,sclk,sdata,busy,cfg_done,wr_ack}
      repeat (3) step();
      check("reset_pins", {adc_reset1, adc_sen1, adc_sclk1, adc_sdata1, busy1, cfg_done1, wr_ack1}, 32'b0100100);
      check("reset_pins2", {adc_reset2, adc_sen2, adc_sclk2, adc_sdata2, busy2, cfg_done2, wr_ack2}, 32'b0100100);

      // Test 1: power-up. Cycle 0 is the first edge with rst low.
      rst = 1'b0; cyc = -1; clear1();
      rhi = 0; rfirst = -1; rlast = -1;
      for (int i = 0; i < 400; i++) begin
         step();
         if (adc_reset1) begin
            rhi++;
            if (rfirst < 0) rfirst = cyc;
            rlast = cyc;
         end
         if (cfg_done1) break;
      end
      done_cyc = cfg_done1 ? cyc : -1;
      check("t1_reset_first", rfirst, 0);
      check("t1_reset_last", rlast, 3);
      check("t1_reset_len", rhi, 4);
      // cfg_done rises on the edge closing cycle 155, so it is first seen in 156.
      check("t1_done_cycle", done_cyc, 156);
      check("t1_busy_at_done", busy1, 1'b0);
      check("t1_nframes", frames1.size(), 2);
      check("t1_frame0", fr1(0), 16'h0001);
      check("t1_frame1", fr1(1), 16'h4210);
      check("t1_sen_fall0", fall1(0), 15);
      check("t1_sen_low0", rise1(0) - fall1(0), 66);
      check("t1_sen_low1", rise1(1) - fall1(1), 66);
      check("t1_spacing", fall1(1) - fall1(0), 71);
      check("t1_gap", done_cyc - rise1(1), 4);

      // Test 2: host write 0x3D/0xA5
      clear1();
      wr_addr = 8'h3D; wr_data = 8'hA5; wr_req = 1'b1;
      acks = 0; bcnt = 0; dlow = 0; seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (wr_ack1) begin
            acks++;
            wr_req = 1'b0;
         end
         if (!cfg_done1) dlow++;
         if (busy1) begin
            bcnt++;
            seen = 1'b1;
         end else if (seen) begin
            break;
         end
      end
      check("t2_ack_count", acks, 1);
      check("t2_busy_len", bcnt, 71);
      check("t2_done_held", dlow, 0);
      check("t2_nframes", frames1.size(), 1);
      check("t2_frame", fr1(0), 16'h3DA5);

      // Test 3: wr_req raised mid-init and held
      wr_req = 1'b0;
      rst = 1'b1; step(); step();
      rst = 1'b0; cyc = -1; clear1();
      wr_addr = 8'h7E; wr_data = 8'h18;
      acks = 0; ack_cyc = -1; done_cyc = -1;
      for (int i = 0; i < 600; i++) begin
         step();
         if (cyc == 19) wr_req = 1'b1;
         if (cfg_done1 && done_cyc < 0) done_cyc = cyc;
         if (wr_ack1) begin
            acks++;
            if (ack_cyc < 0) ack_cyc = cyc;
            wr_req = 1'b0;
         end
         if (ack_cyc >= 0 && !busy1) break;
      end
      check("t3_done_cycle", done_cyc, 156);
      check("t3_ack_cycle", ack_cyc, 157);
      check("t3_ack_count", acks, 1);
      check("t3_nframes", frames1.size(), 3);
      check("t3_frame0", fr1(0), 16'h0001);
      check("t3_host_frame", fr1(2), 16'h7E18);

      // Test 4: start and wr_req together in S_IDLE
      clear1();
      wr_addr = 8'h11; wr_data = 8'h22;
      start = 1'b1; wr_req = 1'b1; cyc = -1;
      step();
      start = 1'b0;
      check("t4_no_ack", wr_ack1, 1'b0);
      check("t4_done_cleared", cfg_done1, 1'b0);
      check("t4_hw_reset", adc_reset1, 1'b1);
      check("t4_busy", busy1, 1'b1);
      acks = 0; ack_cyc = -1; done_cyc = -1;
      for (int i = 0; i < 600; i++) begin
         step();
         if (cfg_done1 && done_cyc < 0) done_cyc = cyc;
         if (wr_ack1) begin
            acks++;
            if (ack_cyc < 0) ack_cyc = cyc;
            wr_req = 1'b0;
         end
         if (ack_cyc >= 0 && !busy1) break;
      end
      check("t4_done_cycle", done_cyc, 156);
      check("t4_ack_cycle", ack_cyc, 157);
      check("t4_ack_count", acks, 1);
      check("t4_frame0", fr1(0), 16'h0001);
      check("t4_frame1", fr1(1), 16'h4210);
      check("t4_host_frame", fr1(2), 16'h1122);

      // Test 5: rst during bit 7 of frame 0 (bit 7 low phase is cycles 43-44)
      wr_req = 1'b0;
      rst = 1'b1; step();
      rst = 1'b0; cyc = -1; clear1();
      for (int i = 0; i < 100; i++) begin
         step();
         if (cyc == 44) break;
      end
      check("t5_mid_frame", {adc_sen1, adc_sclk1, cyc[7:0]}, {2'b00, 8'd44});
      rst = 1'b1;
      step();
      check("t5_abort", {adc_reset1, adc_sen1, adc_sclk1, busy1, cfg_done1, wr_ack1}, 32'b010100);
      step();
      rst = 1'b0; cyc = -1; clear1();
      for (int i = 0; i < 400; i++) begin
         step();
         if (cfg_done1) break;
      end
      done_cyc = cfg_done1 ? cyc : -1;
      check("t5_done_cycle", done_cyc, 156);
      check("t5_sen_fall0", fall1(0), 15);
      check("t5_nframes", frames1.size(), 2);
      check("t5_frame0", fr1(0), 16'h0001);

      // Test 6: protocol checks on the CLK_DIV=4 instance with a random table
      table2 = $urandom();
      rst2 = 1'b0; cyc = -1;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (cfg_done2) break;
      end
      done_cyc = cfg_done2 ? cyc : -1;
      check("t6_done_cycle", done_cyc, 296);
      check("t6_sclk_period", first_per2, 8);
      check("t6_period_errs", per_bad2, 0);
      check("t6_sdata_stable", sdat_bad2, 0);
      check("t6_rises_w0", rp2(0), 16);
      check("t6_rises_w1", rp2(1), 16);
      check("t6_frame0", fr2(0), table2[15:0]);
      check("t6_frame1", fr2(1), table2[31:16]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
